// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the Wishbone SDRAM arbiter.
//   arb_state_t  arbiter FSM states
//   CTI_*        Wishbone cycle type identifiers the arbiter cares about
package sdram_arb_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
endpackage

// File: rtl/wb_sdram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i   per-requester request vector
//   last_i  index of the previous owner; search starts at last_i+1 and wraps
//   gnt_o   one-hot winner (0 when no request)
//   idx_o   index of the winner
//   any_o   at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [IW-1:0] c;
    logic          found;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = '0;
        for (int i = 1; i <= N; i++) begin
            c = IW'((int'(last_i) + i) % N);
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = c;
            end
        end
    end
    assign any_o = found;
endmodule

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: shares one Wishbone slave (SDRAM controller) among NUM_MASTERS masters.
//   wb_clk_i, wb_rst_n_i            clock, async active-low reset
//   m_cyc/stb/we/addr/dat/sel/cti_i packed per-master request buses (master k at [k*W +: W])
//   m_ack_o, m_err_o                per-master ack and one-cycle watchdog error
//   m_dat_o                         read data, broadcast
//   s_*_o, s_ack_i, s_dat_i         slave-side Wishbone port
//   grant_o                         one-hot current owner, 0 when no owner
//   timeout_o                       sticky watchdog flag
module wb_sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 26,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [DW-1:0]               m_dat_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_addr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic [2:0]                  s_cti_o,
    input  logic                        s_ack_i,
    input  logic [DW-1:0]               s_dat_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYC - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d, last_q, last_d;
    logic [WW-1:0]          wdog_q, wdog_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_MASTERS-1:0] req, pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any, in_grant, g_cyc, g_stb, g_eob, expire;
    int                     gsel;

    assign req = m_cyc_i & m_stb_i;

    rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign gsel     = int'(gidx_q);
    assign in_grant = state_q == ARB_GRANT;
    // A fallen cyc suppresses the strobe (and the ack) in the very cycle it falls.
    assign g_cyc    = in_grant & m_cyc_i[gidx_q];
    assign g_stb    = g_cyc & m_stb_i[gidx_q];
    assign g_eob    = s_ack_i & (m_cti_i[gsel*3 +: 3] == CTI_EOB);
    // An ack in the expiry cycle wins: the transfer completed, so no error.
    assign expire   = g_stb & ~s_ack_i & (wdog_q == WD_MAX);

    assign s_cyc_o   = g_cyc;
    assign s_stb_o   = g_stb;
    assign s_we_o    = in_grant & m_we_i[gidx_q];
    assign s_addr_o  = in_grant ? m_addr_i[gsel*AW +: AW] : '0;
    assign s_dat_o   = in_grant ? m_dat_i[gsel*DW +: DW] : '0;
    assign s_sel_o   = in_grant ? m_sel_i[gsel*SW +: SW] : '0;
    assign s_cti_o   = in_grant ? m_cti_i[gsel*3 +: 3] : '0;
    assign m_ack_o   = g_cyc ? (NUM_MASTERS'(s_ack_i) << gidx_q) : '0;
    assign m_err_o   = expire ? (NUM_MASTERS'(1) << gidx_q) : '0;
    assign m_dat_o   = s_dat_i;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q | expire;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    wdog_d  = '0;
                end
            end
            ARB_GRANT: begin
                wdog_d = s_ack_i ? '0 : (g_stb && wdog_q != WD_MAX) ? wdog_q + 1'b1 : wdog_q;
                if (!g_cyc || g_eob || expire) begin
                    state_d = ARB_RELEASE;
                    grant_d = '0;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
                last_d  = gidx_q;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IW'(NUM_MASTERS - 1);
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb_wb_sdram_arbiter: randomized scoreboard bench for wb_sdram_arbiter.
module tb_wb_sdram_arbiter;
    localparam int N  = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 256;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic          we;
        logic [2:0]    cti;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_dat = '0;
    logic [N*SW-1:0] m_sel = '0;
    logic [N*3-1:0]  m_cti = '0;
    logic            s_ack = 1'b0;
    logic [DW-1:0]   s_dat = '0;

    logic [N-1:0]  m_ack_o, m_err_o, grant_o;
    logic [DW-1:0] m_dat_o, s_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o, timeout_o;
    logic [AW-1:0] s_addr_o;
    logic [SW-1:0] s_sel_o;
    logic [2:0]    s_cti_o;

    always #5 clk = ~clk;

    wb_sdram_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_addr_i(m_addr),
        .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_ack_i(s_ack), .s_dat_i(s_dat),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t expq[N][$];
    bit    noack[N];
    int    order_log[$];
    int    err_lat = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drop(input int k);
        m_cyc[k] = 1'b0;
        m_stb[k] = 1'b0;
        m_we[k]  = 1'b0;
        m_cti[k*3 +: 3] = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    // One Wishbone cycle of nb beats from master k. Inputs change at negedge,
    // ack/err are sampled 3 time units later, after the slave has responded.
    task automatic run_job(input int k, input int nb, input bit burst, input int drop_after,
                           input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic we0);
        beat_t b;
        int    waited;
        @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            b.addr = a0 + AW'(4 * i);
            b.dat  = (i == 0) ? d0 : DW'($urandom);
            b.sel  = SW'($urandom_range(1, 15));
            b.we   = we0;
            b.cti  = !burst ? 3'b000 : (i == nb - 1) ? 3'b111 : 3'b010;
            m_cyc[k] = 1'b1;
            m_stb[k] = 1'b1;
            m_we[k]  = b.we;
            m_addr[k*AW +: AW] = b.addr;
            m_dat[k*DW +: DW]  = b.dat;
            m_sel[k*SW +: SW]  = b.sel;
            m_cti[k*3 +: 3]    = b.cti;
            expq[k].push_back(b);
            waited = 0;
            forever begin
                #3;
                if (!rst_n) begin
                    drop(k);
                    expq[k].delete();
                    return;
                end
                if (m_ack_o[k]) break;
                if (m_err_o[k]) begin
                    @(negedge clk);
                    drop(k);
                    return;
                end
                waited++;
                if (drop_after > 0 && waited >= drop_after) begin
                    @(negedge clk);
                    drop(k);
                    void'(expq[k].pop_back());
                    return;
                end
                if (waited > 2000) begin
                    chk($sformatf("ack_wait_m%0d", k), 64'(waited), 64'd0);
                    @(negedge clk);
                    drop(k);
                    expq[k].delete();
                    return;
                end
                @(negedge clk);
            end
            @(negedge clk);
        end
        drop(k);
    endtask

    task automatic rand_master(input int k);
        repeat (8) begin
            idle($urandom_range(0, 4));
            run_job(k, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0,
                    AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    // Slave: acks a presented strobe about 2/3 of the time unless the owner is marked as never-acked.
    initial forever begin
        @(negedge clk);
        #1;
        s_ack = 1'b0;
        if (s_stb_o) begin
            int o;
            o = 0;
            for (int k = 0; k < N; k++) if (grant_o[k]) o = k;
            s_dat = DW'($urandom);
            if (!noack[o]) s_ack = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor + reference model: owner (-1 = none), a pending release cycle,
    // round-robin pointer and stb-without-ack counter, all as plain integers.
    initial begin
        int           own, last, wd, cyc, gstart;
        bit           rel, exp_to, g_ok, stb, to, acked;
        logic [N-1:0] prevg;
        beat_t        b;
        own = -1; last = N - 1; wd = 0; rel = 0; exp_to = 0; prevg = '0; cyc = 0; gstart = 0;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst_n) begin
                chk("rst_grant", 64'(grant_o), 64'd0);
                chk("rst_outs", 64'({s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o}), 64'd0);
                own = -1; last = N - 1; wd = 0; rel = 0; exp_to = 0; prevg = '0;
                continue;
            end
            g_ok  = own >= 0 && !rel;
            stb   = g_ok && m_cyc[own] && m_stb[own];
            to    = stb && !s_ack && wd == TO - 1;
            acked = g_ok && s_ack && m_cyc[own];
            chk("grant", 64'(grant_o), g_ok ? (64'd1 << own) : 64'd0);
            chk("onehot", 64'($onehot0(grant_o)), 64'd1);
            chk("s_cyc", 64'(s_cyc_o), 64'(g_ok && m_cyc[own]));
            chk("s_stb", 64'(s_stb_o), 64'(stb));
            chk("m_ack", 64'(m_ack_o), acked ? (64'd1 << own) : 64'd0);
            chk("m_err", 64'(m_err_o), to ? (64'd1 << own) : 64'd0);
            chk("timeout", 64'(timeout_o), 64'(exp_to));
            chk("m_dat", 64'(m_dat_o), 64'(s_dat));
            if (!g_ok) begin
                chk("s_idle_ctl", 64'({s_we_o, s_addr_o, s_sel_o, s_cti_o}), 64'd0);
                chk("s_idle_dat", 64'(s_dat_o), 64'd0);
            end
            if (grant_o != 0 && prevg == 0) begin
                gstart = cyc;
                for (int k = 0; k < N; k++) if (grant_o[k]) order_log.push_back(k);
            end
            prevg = grant_o;
            if (m_err_o != 0) err_lat = cyc - gstart + 1;
            if (acked) begin
                chk("beat_avail", 64'(expq[own].size() != 0), 64'd1);
                if (expq[own].size() != 0) begin
                    b = expq[own].pop_front();
                    chk("s_addr", 64'(s_addr_o), 64'(b.addr));
                    chk("s_dat", 64'(s_dat_o), 64'(b.dat));
                    chk("s_sel", 64'(s_sel_o), 64'(b.sel));
                    chk("s_we", 64'(s_we_o), 64'(b.we));
                    chk("s_cti", 64'(s_cti_o), 64'(b.cti));
                end
            end
            if (to && expq[own].size() != 0) void'(expq[own].pop_front());
            if (to) exp_to = 1;
            if (rel) begin
                rel = 0;
                own = -1;
            end else if (own < 0) begin
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (last + i) % N;
                    if (own < 0 && m_cyc[c] && m_stb[c]) own = c;
                end
                wd = 0;
            end else begin
                if (!m_cyc[own] || (s_ack && m_cti[own*3 +: 3] == 3'b111) || to) begin
                    rel  = 1;
                    last = own;
                end
                if (s_ack) wd = 0;
                else if (stb && wd < TO - 1) wd++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int exp2[5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < N; k++) noack[k] = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_grant", 64'(grant_o), 64'd0);
        chk("reset_slave", 64'({s_cyc_o, s_stb_o, s_we_o, s_addr_o}), 64'd0);
        chk("reset_timeout", 64'(timeout_o), 64'd0);
        idle(3);
        rst_n = 1'b1;

        // single write from master 0
        order_log.delete();
        run_job(0, 1, 0, 0, 26'h100, 32'hA5A5A5A5, 1'b1);
        idle(4);
        chk("t1_grants", 64'(order_log.size()), 64'd1);
        if (order_log.size() > 0) chk("t1_owner", 64'(order_log[0]), 64'd0);

        // all four at once, master 0 twice
        do_reset();
        order_log.delete();
        fork
            begin
                run_job(0, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b0);
                run_job(0, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b1);
            end
            run_job(1, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b1);
            run_job(2, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b0);
            run_job(3, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b1);
        join
        idle(4);
        chk("t2_grants", 64'(order_log.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < order_log.size()) chk($sformatf("t2_order%0d", i), 64'(order_log[i]), 64'(exp2[i]));

        // burst on master 1 holds off master 2
        order_log.delete();
        fork
            run_job(1, 4, 1, 0, 26'h2000, DW'($urandom), 1'b0);
            begin idle(2); run_job(2, 1, 0, 0, 26'h3000, DW'($urandom), 1'b1); end
        join
        idle(4);
        chk("t3_grants", 64'(order_log.size()), 64'd2);
        if (order_log.size() == 2) chk("t3_order", 64'({order_log[0], order_log[1]}), 64'({32'd1, 32'd2}));

        // watchdog on master 0, then master 1 proceeds
        order_log.delete();
        noack[0] = 1;
        fork
            run_job(0, 1, 0, 0, 26'h40, DW'($urandom), 1'b0);
            begin idle(10); run_job(1, 2, 0, 0, 26'h80, DW'($urandom), 1'b1); end
        join
        noack[0] = 0;
        idle(4);
        chk("t4_err_cycle", 64'(err_lat), 64'(TO));
        chk("t4_timeout_sticky", 64'(timeout_o), 64'd1);
        chk("t4_grants", 64'(order_log.size()), 64'd2);
        if (order_log.size() == 2) chk("t4_order", 64'({order_log[0], order_log[1]}), 64'({32'd0, 32'd1}));

        // reset in the middle of a master 3 burst
        fork
            run_job(3, 16, 1, 0, 26'h500, DW'($urandom), 1'b1);
            begin
                idle(8);
                #2;
                chk("t5_pre_grant", 64'(grant_o), 64'd8);
                rst_n = 1'b0;
                #1;
                chk("t5_rst_grant", 64'(grant_o), 64'd0);
                chk("t5_rst_slave", 64'({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o}), 64'd0);
                chk("t5_rst_acks", 64'({m_ack_o, m_err_o}), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        chk("t5_timeout_cleared", 64'(timeout_o), 64'd0);
        order_log.delete();
        fork
            run_job(0, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b0);
            run_job(1, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b0);
            run_job(2, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b0);
            run_job(3, 1, 0, 0, AW'($urandom), DW'($urandom), 1'b0);
        join
        idle(4);
        chk("t5_grants", 64'(order_log.size()), 64'd4);
        if (order_log.size() > 0) chk("t5_first_owner", 64'(order_log[0]), 64'd0);

        // master 2 abandons an unacked classic cycle
        noack[2] = 1;
        run_job(2, 2, 0, 5, 26'h900, DW'($urandom), 1'b0);
        noack[2] = 0;
        idle(4);
        chk("t6_idle_grant", 64'(grant_o), 64'd0);
        chk("t6_idle_cyc", 64'(s_cyc_o), 64'd0);

        // random contention
        fork
            rand_master(0);
            rand_master(1);
            rand_master(2);
            rand_master(3);
        join
        idle(8);
        for (int k = 0; k < N; k++) chk($sformatf("beats_left_m%0d", k), 64'(expq[k].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
